// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, op-field layout and FSM states.
package alu_pkg;

    // {M,S1,S0} field of the op word
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    localparam int OP_MUL_BIT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_n_if.sv
// Request/result bundle between the register file side and the ALU.
interface alu_seq_n_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] fh;
    logic             co;
    logic             v;
    logic             z;
    logic             n;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  f, fh, co, v, z, n, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output f, fh, co, v, z, n, busy, done
    );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational result, carry and overflow for the eight single-cycle ops.
// Zero latency; no flow control.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             co,
    output logic             v
);
    localparam int MSB = WIDTH - 1;
    localparam int W1  = WIDTH + 1;

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        f   = '0;
        co  = 1'b0;
        v   = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                f   = sum[MSB:0];
                co  = sum[WIDTH];
                v   = (a[MSB] == b[MSB]) && (f[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // carry out of A+~B+1 is the no-borrow flag
                sum = {1'b0, a} + {1'b0, ~b} + W1'(1);
                f   = sum[MSB:0];
                co  = sum[WIDTH];
                v   = (a[MSB] != b[MSB]) && (f[MSB] != a[MSB]);
            end
            OP_INC: begin
                sum = {1'b0, a} + W1'(1);
                f   = sum[MSB:0];
                co  = sum[WIDTH];
                v   = ~a[MSB] & f[MSB];
            end
            OP_DEC: begin
                // adding all-ones carries out unless A is zero
                sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
                f   = sum[MSB:0];
                co  = sum[WIDTH];
                v   = a[MSB] & ~f[MSB];
            end
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_NOT: f = ~a;
        endcase
    end
endmodule

// File: rtl/alu_seq_n.sv
// Registered ALU with multi-cycle unsigned shift-add multiply.
// 1 cycle for logic/arith, WIDTH cycles for multiply; START ignored (not queued) while BUSY.
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_n_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] f_q, fh_q;
    logic             co_q, v_q, z_q, n_q, done_q;

    logic [WIDTH-1:0] core_f;
    logic             core_co, core_v;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] acc_nxt, mplier_nxt;
    logic             accept, accept_mul, last_iter;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op (bus.op[2:0]),
        .a  (bus.a),
        .b  (bus.b),
        .f  (core_f),
        .co (core_co),
        .v  (core_v)
    );

    assign accept     = (state_q == ST_IDLE) && bus.start;
    assign accept_mul = accept && bus.op[OP_MUL_BIT];
    assign last_iter  = (state_q == ST_MULT) && (cnt_q == CW'(1));

    // One shift-add step: {acc, mplier} shifts right, product low bits enter the top of mplier
    always_comb begin
        step_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_nxt    = step_sum[WIDTH:1];
        mplier_nxt = {step_sum[0], mplier_q[MSB:1]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_mul) state_d = ST_MULT;
            ST_MULT: if (last_iter)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            f_q      <= '0;
            fh_q     <= '0;
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_mul) begin
                mcand_q  <= bus.a;
                mplier_q <= bus.b;
                acc_q    <= '0;
                cnt_q    <= CW'(WIDTH);
            end else if (accept) begin
                f_q    <= core_f;
                fh_q   <= '0;
                co_q   <= core_co;
                v_q    <= core_v;
                z_q    <= (core_f == '0);
                n_q    <= core_f[MSB];
                done_q <= 1'b1;
            end else if (state_q == ST_MULT) begin
                acc_q    <= acc_nxt;
                mplier_q <= mplier_nxt;
                cnt_q    <= cnt_q - CW'(1);
                if (last_iter) begin
                    f_q    <= mplier_nxt;
                    fh_q   <= acc_nxt;
                    co_q   <= |acc_nxt;
                    v_q    <= 1'b0;
                    z_q    <= (acc_nxt == '0) && (mplier_nxt == '0);
                    n_q    <= mplier_nxt[MSB];
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.f    = f_q;
    assign bus.fh   = fh_q;
    assign bus.co   = co_q;
    assign bus.v    = v_q;
    assign bus.z    = z_q;
    assign bus.n    = n_q;
    assign bus.busy = (state_q == ST_MULT);
    assign bus.done = done_q;
endmodule
